// File: rtl/ann_classifier_seq.sv
// ann_classifier_seq: 2-layer MLP stage classifier, one shared MAC, serial features, runtime-writable weights.
// Define ANN_MARGIN_EN to add out_margin (saturated best minus runner-up score).
module ann_classifier_seq #(
    parameter int N_FEAT  = 8,
    parameter int N_HID   = 4,
    parameter int N_CLASS = 4,
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40,
    parameter int CLS_W   = $clog2(N_CLASS),
    parameter int W_DEPTH = N_HID*N_FEAT+N_HID+N_CLASS*N_HID+N_CLASS,
    parameter int WA_W    = $clog2(W_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 w_we,
    input  logic [WA_W-1:0]      w_addr,
    input  logic signed [DW-1:0] w_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CLS_W-1:0]     out_class,
    output logic signed [DW-1:0] out_score,
`ifdef ANN_MARGIN_EN
    output logic signed [DW-1:0] out_margin,
`endif
    output logic                 busy
);
    localparam int B1  = N_HID*N_FEAT;
    localparam int B2  = B1+N_HID;
    localparam int BB2 = B2+N_CLASS*N_HID;
    localparam int CW  = $clog2(N_FEAT+N_HID+N_CLASS+1);
    localparam int FW  = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
    localparam int HW  = N_HID > 1 ? $clog2(N_HID) : 1;
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, L1, L2, FIN, OUT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d, nrn_q, nrn_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, v;
    logic signed [DW-1:0]     wmem [W_DEPTH];
    logic signed [DW-1:0]     feat_q [N_FEAT];
    logic signed [DW-1:0]     hid_q [N_HID];
    logic signed [DW-1:0]     best_q, score_q, w_rd, mac_a, v_sat;
    logic [CLS_W-1:0]         idx_q, cls_q;
    logic signed [2*DW-1:0]   prod;
    logic [WA_W-1:0]          wa;
    logic                     fin, last_nrn;

    // cnt reaching the fan-in marks the finalise cycle, which reads the bias instead of a weight
    assign fin      = (state_q == L1) ? (cnt_q == CW'(N_FEAT)) : (cnt_q == CW'(N_HID));
    assign last_nrn = nrn_q == ((state_q == L1) ? CW'(N_HID-1) : CW'(N_CLASS-1));
    assign wa       = (state_q == L1)
                    ? (fin ? WA_W'(B1) + WA_W'(nrn_q) : WA_W'(nrn_q)*WA_W'(N_FEAT) + WA_W'(cnt_q))
                    : (fin ? WA_W'(BB2) + WA_W'(nrn_q) : WA_W'(B2) + WA_W'(nrn_q)*WA_W'(N_HID) + WA_W'(cnt_q));
    assign w_rd     = wmem[wa];
    assign mac_a    = (state_q == L1) ? feat_q[FW'(cnt_q)] : hid_q[HW'(cnt_q)];
    assign prod     = mac_a * w_rd;
    assign v        = (acc_q + (ACC_W'(w_rd) <<< FRAC)) >>> FRAC;
    assign v_sat    = (v > SMAX) ? SMAX[DW-1:0] : (v < SMIN) ? SMIN[DW-1:0] : v[DW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nrn_d   = nrn_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                cnt_d   = (cnt_q == CW'(N_FEAT-1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(N_FEAT-1)) ? L1 : IDLE;
            end
            L1, L2: if (!fin) begin
                acc_d = acc_q + ACC_W'(prod);
                cnt_d = cnt_q + 1'b1;
            end else begin
                acc_d   = '0;
                cnt_d   = '0;
                nrn_d   = last_nrn ? '0 : nrn_q + 1'b1;
                state_d = !last_nrn ? state_q : (state_q == L1) ? L2 : FIN;
            end
            FIN:     state_d = OUT;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nrn_q   <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            cls_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nrn_q   <= nrn_d;
            acc_q   <= acc_d;
            if (state_q == L2 && fin && (nrn_q == '0 || v_sat > best_q)) begin
                best_q <= v_sat;
                idx_q  <= CLS_W'(nrn_q);
            end
            if (state_q == FIN) begin
                cls_q   <= idx_q;
                score_q <= best_q;
            end
        end
    end

    // weights, features and hidden activations are plain storage, untouched by reset
    always_ff @(posedge clk) begin
        if (w_we && state_q == IDLE && 32'(w_addr) < W_DEPTH) wmem[w_addr] <= w_data;
        if (state_q == IDLE && in_valid) feat_q[FW'(cnt_q)] <= in_data;
        if (state_q == L1 && fin) hid_q[HW'(nrn_q)] <= v_sat[DW-1] ? '0 : v_sat;
    end

`ifdef ANN_MARGIN_EN
    logic signed [DW-1:0] sec_q, marg_q;
    logic signed [DW:0]   diff;
    assign diff = {best_q[DW-1], best_q} - {sec_q[DW-1], sec_q};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_q  <= '0;
            marg_q <= '0;
        end else begin
            if (state_q == L2 && fin)
                sec_q <= (nrn_q == '0) ? SMIN[DW-1:0] : (v_sat > best_q) ? best_q : (v_sat > sec_q) ? v_sat : sec_q;
            if (state_q == FIN)
                marg_q <= (diff[DW] != diff[DW-1]) ? (diff[DW] ? SMIN[DW-1:0] : SMAX[DW-1:0]) : diff[DW-1:0];
        end
    end
    assign out_margin = marg_q;
`endif

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign busy      = state_q != IDLE;
    assign out_class = cls_q;
    assign out_score = score_q;
endmodule
